// File: rtl/div_pkg.sv
// Shared definitions for the EX-stage divider: FSM states, configuration
// legality check and the ALU decoder op codes that select signed division.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    // Quotient bits retired per cycle may only be 1, 2 or 4 and must tile the operand width.
    function automatic bit bpc_is_legal(input int bpc, input int width);
        return ((bpc == 1) || (bpc == 2) || (bpc == 4)) && ((width % bpc) == 0)
            && (width >= 4) && ((width % 2) == 0);
    endfunction

    localparam logic [5:0] EXE_DIV_OP  = 6'h1A;
    localparam logic [5:0] EXE_DIVU_OP = 6'h1B;

    function automatic logic op_is_signed(input logic [5:0] op);
        return (op == EXE_DIV_OP);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor magnitude, keep the difference when it is non-negative.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   i_rem,
    input  logic [WIDTH-1:0] i_divisor,
    input  logic             i_bit,
    output logic [WIDTH:0]   o_rem,
    output logic             o_q
);

    logic [WIDTH+1:0] w_shift;
    logic [WIDTH+1:0] w_diff;

    assign w_shift = {i_rem, i_bit};
    assign w_diff  = w_shift - {2'b00, i_divisor};
    assign o_q     = ~w_diff[WIDTH+1];
    assign o_rem   = o_q ? w_diff[WIDTH:0] : w_shift[WIDTH:0];

endmodule

// File: rtl/div_unit_param.sv
// Multi-cycle signed/unsigned integer divider producing {remainder, quotient}
// for HI/LO, with cancel for pipeline flush and a defined divide-by-zero result.
module div_unit_param
    import div_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic               clk,
    input  logic               sclr,
    input  logic               start,
    input  logic               signed_op,
    input  logic               cancel,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               result_ok,
    output logic               div_zero,
    output logic [2*WIDTH-1:0] result
);

    localparam int N     = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(N) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    if (!bpc_is_legal(BITS_PER_CYCLE, WIDTH)) begin : g_bad_cfg
        $error("div_unit_param: illegal WIDTH/BITS_PER_CYCLE combination");
    end

    div_state_t r_state, w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH:0]     r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_divisor;
    logic               r_sign_q, r_sign_r, r_zero;
    logic               r_div_zero;
    logic [2*WIDTH-1:0] r_result;

    logic               w_take, w_b_zero, w_a_neg, w_b_neg;
    logic [WIDTH-1:0]   w_a_mag, w_b_mag, w_quo_next, w_quo_fix, w_rem_lo, w_rem_fix;
    logic [BITS_PER_CYCLE:0][WIDTH:0] w_rem_chain;
    logic [BITS_PER_CYCLE-1:0]        w_qbits;

    assign w_take   = (r_state == IDLE) && start && !cancel;
    assign w_b_zero = (b == '0);
    assign w_a_neg  = signed_op & a[WIDTH-1];
    assign w_b_neg  = signed_op & b[WIDTH-1];
    assign w_a_mag  = w_a_neg ? -a : a;
    assign w_b_mag  = w_b_neg ? -b : b;

    // r_quo starts as the dividend; its MSBs feed the steps while quotient bits shift in below.
    assign w_rem_chain[0] = r_rem;
    for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_step
        div_step #(.WIDTH(WIDTH)) u_step (
            .i_rem    (w_rem_chain[gi]),
            .i_divisor(r_divisor),
            .i_bit    (r_quo[WIDTH-1-gi]),
            .o_rem    (w_rem_chain[gi+1]),
            .o_q      (w_qbits[BITS_PER_CYCLE-1-gi])
        );
    end

    if (WIDTH > BITS_PER_CYCLE) begin : g_shift
        assign w_quo_next = {r_quo[WIDTH-BITS_PER_CYCLE-1:0], w_qbits};
    end else begin : g_whole
        assign w_quo_next = w_qbits;
    end

    assign w_rem_lo  = r_rem[WIDTH-1:0];
    assign w_quo_fix = r_sign_q ? -r_quo : r_quo;
    assign w_rem_fix = r_sign_r ? -w_rem_lo : w_rem_lo;

    always_ff @(posedge clk) begin
        if (sclr) r_state <= IDLE;
        else      r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_take) w_state_next = w_b_zero ? FIX : DIV;
            DIV: begin
                if (cancel)                w_state_next = IDLE;
                else if (r_cnt == LAST_CNT) w_state_next = FIX;
            end
            FIX:     w_state_next = cancel ? IDLE : DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sclr) begin
            r_cnt      <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_divisor  <= '0;
            r_sign_q   <= 1'b0;
            r_sign_r   <= 1'b0;
            r_zero     <= 1'b0;
            r_div_zero <= 1'b0;
            r_result   <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_take) begin
                    r_cnt     <= '0;
                    r_rem     <= '0;
                    // Divide by zero returns the raw dividend in HI, so skip the magnitude.
                    r_quo     <= w_b_zero ? a : w_a_mag;
                    r_divisor <= w_b_mag;
                    r_sign_q  <= w_a_neg ^ w_b_neg;
                    r_sign_r  <= w_a_neg;
                    r_zero    <= w_b_zero;
                end
                DIV: begin
                    if (cancel) begin
                        r_cnt <= '0;
                    end else begin
                        r_rem <= w_rem_chain[BITS_PER_CYCLE];
                        r_quo <= w_quo_next;
                        r_cnt <= (r_cnt == LAST_CNT) ? '0 : r_cnt + 1'b1;
                    end
                end
                FIX: if (!cancel) begin
                    r_result   <= r_zero ? {r_quo, {WIDTH{1'b1}}} : {w_rem_fix, w_quo_fix};
                    r_div_zero <= r_zero;
                end
                default: ;
            endcase
        end
    end

    assign busy      = (r_state != IDLE);
    assign result_ok = (r_state == DONE);
    assign div_zero  = r_div_zero;
    assign result    = r_result;

endmodule

// File: tb/tb_div_unit_param.sv
// Drives BPC=1/2/4 dividers in lockstep; expected results are queued at issue
// and checked by per-instance monitors whenever result_ok fires.
module tb_div_unit_param;

    localparam int W = 32;
    localparam logic [W-1:0] MIN_NEG = 32'h8000_0000;

    typedef struct {
        logic [2*W-1:0] res;
        logic           dz;
        int             issue;
    } exp_t;

    logic clk = 1'b0;
    logic sclr, start, signed_op, cancel;
    logic [W-1:0] a, b;
    logic [2:0] busy_v, rok_v, dz_v;
    logic [2:0][2*W-1:0] res_v;

    exp_t exp_q[$];
    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    logic [2*W-1:0] last_res = '0;
    logic last_dz = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int bpc, input logic [2*W-1:0] act,
                         input logic [2*W-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s bpc=%0d actual=%h required=%h", name, bpc, act, req);
        end
    endtask

    // Reference: plain 64-bit integer division (truncating, remainder follows dividend).
    function automatic exp_t ref_div(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic s);
        exp_t e;
        longint sa, sb, q, r;
        e.issue = 0;
        if (bb == '0) begin
            e.res = {aa, {W{1'b1}}};
            e.dz  = 1'b1;
        end else begin
            if (s) begin
                sa = longint'($signed(aa));
                sb = longint'($signed(bb));
            end else begin
                sa = longint'({32'h0, aa});
                sb = longint'({32'h0, bb});
            end
            q = sa / sb;
            r = sa % sb;
            e.res = {r[W-1:0], q[W-1:0]};
            e.dz  = 1'b0;
        end
        return e;
    endfunction

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int BPC = 1 << gi;
        int rd_idx = 0;
        exp_t e;

        div_unit_param #(.WIDTH(W), .BITS_PER_CYCLE(BPC)) u_dut (
            .clk      (clk),
            .sclr     (sclr),
            .start    (start),
            .signed_op(signed_op),
            .cancel   (cancel),
            .a        (a),
            .b        (b),
            .busy     (busy_v[gi]),
            .result_ok(rok_v[gi]),
            .div_zero (dz_v[gi]),
            .result   (res_v[gi])
        );

        always @(negedge clk) begin
            if (rok_v[gi] === 1'b1) begin
                if (rd_idx >= exp_q.size()) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_result_ok bpc=%0d actual=%h required=none", BPC, res_v[gi]);
                end else begin
                    e = exp_q[rd_idx];
                    rd_idx++;
                    check("result", BPC, res_v[gi], e.res);
                    check("div_zero", BPC, 64'(dz_v[gi]), 64'(e.dz));
                    check("latency", BPC, 64'(cyc - e.issue), e.dz ? 64'd2 : 64'(W / BPC + 2));
                end
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (busy_v !== 3'b000 && n < 200);
        if (busy_v !== 3'b000) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_idle_timeout actual busy=%b required=000", busy_v);
        end
    endtask

    task automatic issue(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic s, input bit keep);
        exp_t e;
        wait_idle();
        a = aa;
        b = bb;
        signed_op = s;
        start = 1'b1;
        if (keep) begin
            e = ref_div(aa, bb, s);
            e.issue = cyc;
            exp_q.push_back(e);
            last_res = e.res;
            last_dz  = e.dz;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        signed_op = 1'($urandom);
        check("busy_after_start", 0, 64'(busy_v), 64'h7);
    endtask

    // All three instances are still in DIV two cycles later, so this start must be ignored.
    task automatic ignored_start();
        repeat (2) begin @(posedge clk); #1; end
        a = $urandom;
        b = 32'd3;
        signed_op = 1'($urandom);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_busy"}, 0, 64'(busy_v), 64'h0);
        check({name, "_result_ok"}, 0, 64'(rok_v), 64'h0);
        check({name, "_div_zero"}, 0, 64'(dz_v), 64'h0);
        for (int i = 0; i < 3; i++) check({name, "_result"}, 1 << i, res_v[i], 64'h0);
    endtask

    initial begin
        sclr = 1'b1;
        start = 1'b0;
        cancel = 1'b0;
        signed_op = 1'b0;
        a = '0;
        b = '0;
        repeat (3) @(posedge clk);
        #1;
        sclr = 1'b0;
        check_all_zero("reset");

        issue(32'hFFFF_FFFD, 32'd2, 1'b1, 1'b1);
        ignored_start();
        issue(32'hFFFF_FFFD, 32'hFFFF_FFF0, 1'b0, 1'b1);
        issue(32'hFFFF_FFFD, 32'hFFFF_FFF0, 1'b1, 1'b1);
        issue(32'd255, 32'd16, 1'b1, 1'b1);
        ignored_start();
        issue(32'd255, 32'd16, 1'b0, 1'b1);
        issue(32'h1234_5678, 32'd0, 1'b0, 1'b1);
        issue(MIN_NEG, 32'hFFFF_FFFF, 1'b1, 1'b1);

        // Cancel mid-DIV: no result, outputs keep the last written value.
        issue(32'h7654_3210, 32'd7, 1'b1, 1'b0);
        repeat (5) begin @(posedge clk); #1; end
        cancel = 1'b1;
        @(posedge clk);
        #1;
        cancel = 1'b0;
        check("cancel_busy", 0, 64'(busy_v), 64'h0);
        for (int i = 0; i < 3; i++) begin
            check("cancel_result_kept", 1 << i, res_v[i], last_res);
            check("cancel_div_zero_kept", 1 << i, 64'(dz_v[i]), 64'(last_dz));
        end

        // start together with cancel in IDLE is ignored.
        wait_idle();
        a = 32'd99;
        b = 32'd3;
        start = 1'b1;
        cancel = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cancel = 1'b0;
        check("start_with_cancel_busy", 0, 64'(busy_v), 64'h0);

        // Synchronous clear mid-operation zeroes every output.
        issue(32'hDEAD_BEEF, 32'd5, 1'b0, 1'b0);
        repeat (4) begin @(posedge clk); #1; end
        sclr = 1'b1;
        @(posedge clk);
        #1;
        sclr = 1'b0;
        check_all_zero("sclr_mid_op");
        last_res = '0;
        last_dz  = 1'b0;

        for (int k = 0; k < 350; k++) begin
            logic [W-1:0] ra, rb;
            int m;
            ra = $urandom;
            rb = $urandom;
            m  = $urandom_range(0, 9);
            case (m)
                0: rb = '0;
                1: begin ra = MIN_NEG; rb = '1; end
                2: rb = W'($urandom_range(1, 15));
                3: rb = '1;
                4: ra = W'($urandom_range(0, 100));
                5: ra = MIN_NEG;
                default: ;
            endcase
            issue(ra, rb, 1'($urandom), 1'b1);
        end

        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        check("results_seen", 1, 64'(g_dut[0].rd_idx), 64'(exp_q.size()));
        check("results_seen", 2, 64'(g_dut[1].rd_idx), 64'(exp_q.size()));
        check("results_seen", 4, 64'(g_dut[2].rd_idx), 64'(exp_q.size()));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
